// File: rtl/pend_request_collector_pkg.sv
// Shared widths, FSM state type and clear-mask decode for the pending request collector.
package pend_collect_pkg;

  localparam int unsigned PEND_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CLR_IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_HI = 1'b1
  } pend_state_t;

  function automatic logic [PEND_W-1:0] clr_decode(input logic [CLR_IDX_W-1:0] idx,
                                                   input logic                 en);
    logic [PEND_W-1:0] mask;
    mask = '0;
    if (en) mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/pend_request_collector_if.sv
// Request/clear bus and pending-vector outputs of the collector.
interface pend_request_collector_if;
  import pend_collect_pkg::*;

  logic [BYTE_W-1:0]    req_byte;
  logic                 req_hi;
  logic                 req_valid;
  logic                 clr_valid;
  logic [CLR_IDX_W-1:0] clr_idx;
  logic [PEND_W-1:0]    pend;
  logic                 pend_any;
  logic                 busy;
  logic                 timeout;

  modport master (
    output req_byte, req_hi, req_valid, clr_valid, clr_idx,
    input  pend, pend_any, busy, timeout
  );

  modport slave (
    input  req_byte, req_hi, req_valid, clr_valid, clr_idx,
    output pend, pend_any, busy, timeout
  );

endinterface

// File: rtl/pend_request_collector_timeout_ctr.sv
// Wait counter for the high byte; tc_o flags the last allowed waiting cycle (TIMEOUT-1).
module pend_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TcVal = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/pend_request_collector.sv
// Collects two byte writes into a sticky 16-bit pending vector with indexed clears.
// Define PEND_EDGE_EN for edge mode (only 0->1 lane transitions set pending bits).
module pend_request_collector
  import pend_collect_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input logic                      clk,
  input logic                      rst,
  pend_request_collector_if.slave  bus_io
);

  pend_state_t       state_q, state_d;
  logic [BYTE_W-1:0] lo_buf_q, lo_buf_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              pend_any_q;
  logic              timeout_q, timeout_d;

  logic              lo_commit, hi_commit;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [BYTE_W-1:0] set_lo, set_hi;
  logic [PEND_W-1:0] clr_mask;

  pend_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    lo_buf_d  = lo_buf_q;
    lo_commit = 1'b0;
    hi_commit = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_io.req_valid) begin
          if (bus_io.req_hi) begin
            hi_commit = 1'b1;
          end else begin
            lo_buf_d = bus_io.req_byte;
            cnt_clr  = 1'b1;
            state_d  = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (bus_io.req_valid && bus_io.req_hi) begin
          lo_commit = 1'b1;
          hi_commit = 1'b1;
          state_d   = IDLE;
        end else if (bus_io.req_valid) begin
          // A second low byte flushes the buffered one and restarts the wait.
          lo_commit = 1'b1;
          lo_buf_d  = bus_io.req_byte;
          cnt_clr   = 1'b1;
        end else if (cnt_tc) begin
          lo_commit = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PEND_EDGE_EN
  logic [PEND_W-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    set_lo   = '0;
    set_hi   = '0;
    if (lo_commit) begin
      set_lo         = lo_buf_q & ~shadow_q[BYTE_W-1:0];
      shadow_d[BYTE_W-1:0] = lo_buf_q;
    end
    if (hi_commit) begin
      set_hi         = bus_io.req_byte & ~shadow_q[PEND_W-1:BYTE_W];
      shadow_d[PEND_W-1:BYTE_W] = bus_io.req_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end
`else
  always_comb begin
    set_lo = lo_commit ? lo_buf_q : '0;
    set_hi = hi_commit ? bus_io.req_byte : '0;
  end
`endif

  // Set is OR'd after the clear so a same-cycle set/clear keeps the request.
  always_comb begin
    clr_mask = clr_decode(bus_io.clr_idx, bus_io.clr_valid);
    pend_d   = (pend_q & ~clr_mask) | {set_hi, set_lo};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lo_buf_q   <= '0;
      pend_q     <= '0;
      pend_any_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_buf_q   <= lo_buf_d;
      pend_q     <= pend_d;
      pend_any_q <= |pend_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus_io.pend     = pend_q;
  assign bus_io.pend_any = pend_any_q;
  assign bus_io.busy     = (state_q == WAIT_HI);
  assign bus_io.timeout  = timeout_q;

endmodule
